// File: rtl/frame_draw_ctrl.sv
// Per-frame draw sequencer: background ROM scan, then sprite, merged into one
// registered x/y/colour/plot write port for the 160x120 VGA adapter.
module frame_draw_ctrl #(
  parameter int unsigned SCREEN_W     = 160,
  parameter int unsigned SCREEN_H     = 120,
  parameter logic [2:0]  WALL_COLOUR  = 3'b001,
  parameter logic [2:0]  FLOOR_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  output logic       bg_enable,
  input  logic       bg_done,
  input  logic [7:0] bg_x,
  input  logic [6:0] bg_y,
  input  logic       bg_colour,
  output logic       sprite_enable,
  input  logic       sprite_done,
  input  logic [7:0] sprite_x,
  input  logic [6:0] sprite_y,
  input  logic [2:0] sprite_colour,
  input  logic       sprite_valid,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       frame_busy,
  output logic       overrun
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    BG_RUN   = 3'd1,
    BG_FLUSH = 3'd2,
    SP_RUN   = 3'd3,
    SP_FLUSH = 3'd4
  } state_t;

  localparam logic [8:0] X_LIMIT = 9'(SCREEN_W);
  localparam logic [7:0] Y_LIMIT = 8'(SCREEN_H);

  function automatic logic on_screen(input logic [7:0] x, input logic [6:0] y);
    return ({1'b0, x} < X_LIMIT) && ({1'b0, y} < Y_LIMIT);
  endfunction

  state_t     state_r, state_nx_s;
  logic       first_r;
  logic       pending_r, pending_nx_s;
  logic       overrun_r, overrun_nx_s;
  logic       busy_s;

  logic [7:0] stage_x_r;
  logic [6:0] stage_y_r;
  logic       stage_valid_r;

  logic [7:0] vga_x_r, wr_x_s;
  logic [6:0] vga_y_r, wr_y_s;
  logic [2:0] vga_colour_r, wr_colour_s;
  logic       vga_plot_r, wr_plot_s;

  assign busy_s       = (state_r != IDLE);
  assign overrun_nx_s = overrun_r | (frame_tick & pending_r & busy_s);

  // Done is masked in the first cycle of each run state: it is stale from the last frame.
  assign bg_enable     = (state_r == BG_RUN) && !(bg_done && !first_r);
  assign sprite_enable = (state_r == SP_RUN) && !(sprite_done && !first_r);
  assign frame_busy    = busy_s;

  // Frame sequencing and single-entry tick queue
  always_comb begin
    state_nx_s   = state_r;
    pending_nx_s = pending_r | frame_tick;
    case (state_r)
      IDLE: begin
        if (frame_tick || pending_r) begin
          state_nx_s   = BG_RUN;
          pending_nx_s = pending_r & frame_tick;
        end else begin
          state_nx_s   = IDLE;
          pending_nx_s = 1'b0;
        end
      end
      BG_RUN: begin
        if (bg_done && !first_r) begin
          state_nx_s = BG_FLUSH;
        end else begin
          state_nx_s = BG_RUN;
        end
      end
      BG_FLUSH: state_nx_s = SP_RUN;
      SP_RUN: begin
        if (sprite_done && !first_r) begin
          state_nx_s = SP_FLUSH;
        end else begin
          state_nx_s = SP_RUN;
        end
      end
      SP_FLUSH: state_nx_s = IDLE;
      default: begin
        state_nx_s   = IDLE;
        pending_nx_s = 1'b0;
      end
    endcase
  end

  // Write-port source select; the background path reads from the stage register
  always_comb begin
    wr_x_s      = 8'd0;
    wr_y_s      = 7'd0;
    wr_colour_s = 3'd0;
    wr_plot_s   = 1'b0;
    case (state_r)
      BG_RUN, BG_FLUSH: begin
        wr_x_s      = stage_x_r;
        wr_y_s      = stage_y_r;
        wr_colour_s = bg_colour ? WALL_COLOUR : FLOOR_COLOUR;
        wr_plot_s   = stage_valid_r && on_screen(stage_x_r, stage_y_r);
      end
      SP_RUN: begin
        wr_x_s      = sprite_x;
        wr_y_s      = sprite_y;
        wr_colour_s = sprite_colour;
        wr_plot_s   = sprite_valid && on_screen(sprite_x, sprite_y);
      end
      default: begin
        wr_x_s      = 8'd0;
        wr_y_s      = 7'd0;
        wr_colour_s = 3'd0;
        wr_plot_s   = 1'b0;
      end
    endcase
  end

  // Control state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      first_r   <= 1'b0;
      pending_r <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      first_r   <= (state_nx_s != state_r);
      pending_r <= pending_nx_s;
      overrun_r <= overrun_nx_s;
    end
  end

  // Stage register aligns coordinates with the ROM's one-cycle read latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_x_r     <= 8'd0;
      stage_y_r     <= 7'd0;
      stage_valid_r <= 1'b0;
      vga_x_r       <= 8'd0;
      vga_y_r       <= 7'd0;
      vga_colour_r  <= 3'd0;
      vga_plot_r    <= 1'b0;
    end else begin
      stage_x_r     <= bg_x;
      stage_y_r     <= bg_y;
      stage_valid_r <= (state_r == BG_RUN);
      vga_x_r       <= wr_x_s;
      vga_y_r       <= wr_y_s;
      vga_colour_r  <= wr_colour_s;
      vga_plot_r    <= wr_plot_s;
    end
  end

  assign vga_x      = vga_x_r;
  assign vga_y      = vga_y_r;
  assign vga_colour = vga_colour_r;
  assign vga_plot   = vga_plot_r;
  assign overrun    = overrun_r;

endmodule

// File: tb/tb_frame_draw_ctrl.sv
// Bench for frame_draw_ctrl: behavioural background/sprite drawers plus a
// queue of expected adapter writes derived from what the drawers present.
module tb_frame_draw_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       bg_enable, bg_done, bg_colour;
  logic [7:0] bg_x;
  logic [6:0] bg_y;
  logic       sprite_enable, sprite_done, sprite_valid;
  logic [7:0] sprite_x;
  logic [6:0] sprite_y;
  logic [2:0] sprite_colour;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot, frame_busy, overrun;

  always #5 clk = ~clk;

  frame_draw_ctrl dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .bg_enable(bg_enable), .bg_done(bg_done), .bg_x(bg_x), .bg_y(bg_y), .bg_colour(bg_colour),
    .sprite_enable(sprite_enable), .sprite_done(sprite_done), .sprite_x(sprite_x),
    .sprite_y(sprite_y), .sprite_colour(sprite_colour), .sprite_valid(sprite_valid),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .frame_busy(frame_busy), .overrun(overrun)
  );

  // Background drawer: raster scan of a rectangle, ROM bit = x[0] one cycle late
  logic [7:0] bx = 8'd0, bx0 = 8'd0, bxmax = 8'd0;
  logic [6:0] by = 7'd0, by0 = 7'd0, bymax = 7'd0;
  logic       bdone = 1'b0, brun = 1'b0, brom = 1'b0, bg_rearm = 1'b0;

  always @(posedge clk) begin
    brom <= bx[0];
    if (bg_rearm) begin
      bx <= bx0;
      by <= by0;
    end else if (bg_enable) begin
      if (!brun) bdone <= 1'b0;
      brun <= 1'b1;
      if (bx == bxmax && by == bymax) bdone <= 1'b1;
      else if (bx == bxmax) begin
        bx <= bx0;
        by <= by + 7'd1;
      end else bx <= bx + 8'd1;
    end else brun <= 1'b0;
  end

  assign bg_x = bx;
  assign bg_y = by;
  assign bg_done = bdone;
  assign bg_colour = brom;

  // Sprite drawer: 8x8 block at (sx,sy), per-pixel opacity mask and colour
  logic [7:0]  sx = 8'd0;
  logic [6:0]  sy = 7'd0;
  logic [5:0]  spix = 6'd0;
  logic        sdone = 1'b0, srun = 1'b0, sfin = 1'b1, sp_rearm = 1'b0;
  logic [63:0] smask = 64'd0;
  logic [2:0]  scol [64];

  always @(posedge clk) begin
    if (sp_rearm) begin
      spix <= 6'd0;
      sfin <= 1'b0;
    end else if (sprite_enable) begin
      if (!srun) sdone <= 1'b0;
      srun <= 1'b1;
      if (spix == 6'd63) begin
        sdone <= 1'b1;
        sfin  <= 1'b1;
      end else spix <= spix + 6'd1;
    end else srun <= 1'b0;
  end

  assign sprite_x      = sx + {5'd0, spix[2:0]};
  assign sprite_y      = sy + {4'd0, spix[5:3]};
  assign sprite_colour = scol[spix];
  assign sprite_valid  = smask[spix] & ~sfin;
  assign sprite_done   = sdone;

  typedef struct {
    int         cyc;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } wr_t;

  wr_t expq[$];
  int  cyc = 0, tests = 0, fails = 0, plots = 0;
  int  exp_bg = 0, exp_sp = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: compare the write port against the expected queue, then record new pixels
  task automatic step();
    wr_t e;
    @(negedge clk);
    cyc++;
    check("en_exclusive", 32'(bg_enable & sprite_enable), 32'd0);
    if (vga_plot === 1'b1) plots++;
    if (expq.size() > 0 && expq[0].cyc == cyc) begin
      e = expq.pop_front();
      check("plot", 32'(vga_plot), 32'd1);
      check("vga_x", 32'(vga_x), 32'(e.x));
      check("vga_y", 32'(vga_y), 32'(e.y));
      check("vga_colour", 32'(vga_colour), 32'(e.c));
    end else begin
      check("no_plot", 32'(vga_plot), 32'd0);
    end
    if (bg_enable === 1'b1 && bg_x < 8'd160 && bg_y < 7'd120) begin
      e.cyc = cyc + 2; e.x = bg_x; e.y = bg_y;
      e.c = bg_x[0] ? 3'b001 : 3'b000;
      expq.push_back(e);
    end
    if (sprite_enable === 1'b1 && sprite_valid === 1'b1 && sprite_x < 8'd160 && sprite_y < 7'd120) begin
      e.cyc = cyc + 1; e.x = sprite_x; e.y = sprite_y; e.c = sprite_colour;
      expq.push_back(e);
    end
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic rearm();
    bg_rearm = 1'b1;
    sp_rearm = 1'b1;
    step();
    bg_rearm = 1'b0;
    sp_rearm = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (frame_busy === 1'b1 && n < budget) begin
      step();
      n++;
    end
    check("idle_timeout", 32'(frame_busy), 32'd0);
  endtask

  // Random small frame near the screen corner; expected counts from plain arithmetic
  task automatic setup_random();
    int xe;
    bx0   = 8'($urandom_range(150, 158));
    bxmax = bx0 + 8'($urandom_range(2, 12));
    by0   = 7'($urandom_range(112, 119));
    bymax = 7'($urandom_range(120, 127));
    sx    = 8'($urandom_range(140, 248));
    sy    = 7'($urandom_range(100, 120));
    smask = {$urandom(), $urandom()};
    for (int i = 0; i < 64; i++) scol[i] = 3'($urandom_range(0, 7));
    xe = (int'(bxmax) > 159) ? 159 : int'(bxmax);
    exp_bg = (xe - int'(bx0) + 1) * (120 - int'(by0));
    exp_sp = 0;
    for (int i = 0; i < 64; i++)
      if (smask[i] && (int'(sx) + i % 8) < 160 && (int'(sy) + i / 8) < 120) exp_sp++;
    rearm();
  endtask

  task automatic run_random_frame();
    int p0;
    setup_random();
    p0 = plots;
    pulse_tick();
    wait_idle(3000);
    check("frame_plots", 32'(plots - p0), 32'(exp_bg + exp_sp));
  endtask

  initial begin
    int n, p0, p1;
    for (int i = 0; i < 64; i++) scol[i] = 3'd0;

    #1 reset = 1'b1;
    #1;
    check("rst_bg_enable", 32'(bg_enable), 32'd0);
    check("rst_sprite_enable", 32'(sprite_enable), 32'd0);
    check("rst_vga", {14'd0, vga_x, vga_y, vga_colour}, 32'd0);
    check("rst_plot", 32'(vga_plot), 32'd0);
    check("rst_busy", 32'(frame_busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    step(); step();
    reset = 1'b0;
    step();

    // Full-screen scan including the first off-screen column and row, sprite at (156,10)
    bx0 = 8'd0; by0 = 7'd0; bxmax = 8'd160; bymax = 7'd120;
    sx = 8'd156; sy = 7'd10; smask = '1;
    for (int i = 0; i < 64; i++) scol[i] = 3'($urandom_range(0, 7));
    rearm();
    p0 = plots;
    pulse_tick();
    check("bg_en_first", 32'(bg_enable), 32'd1);
    n = 0;
    while (sprite_enable !== 1'b1 && n < 25000) begin
      step();
      n++;
    end
    check("sp_start", 32'(sprite_enable), 32'd1);
    check("bg_plots", 32'(plots - p0), 32'd19200);
    p1 = plots;
    n = 0;
    while (frame_busy === 1'b1 && n < 200) begin
      check("bg_en_in_sp", 32'(bg_enable), 32'd0);
      step();
      n++;
    end
    check("idle_after_sp", 32'(frame_busy), 32'd0);
    check("sp_plots", 32'(plots - p1), 32'd32);

    // bg_done is still high from the previous frame
    setup_random();
    p0 = plots;
    pulse_tick();
    check("stale_bg_en_c1", 32'(bg_enable), 32'd1);
    step();
    check("stale_bg_en_c2", 32'(bg_enable), 32'd1);
    check("stale_busy", 32'(frame_busy), 32'd1);
    wait_idle(3000);
    check("stale_plots", 32'(plots - p0), 32'(exp_bg + exp_sp));

    for (int k = 0; k < 5; k++) run_random_frame();

    // Second tick mid-frame queues exactly one frame
    setup_random();
    pulse_tick();
    step(); step();
    pulse_tick();
    check("queued_overrun", 32'(overrun), 32'd0);
    wait_idle(3000);
    step();
    check("queued_start_busy", 32'(frame_busy), 32'd1);
    check("queued_start_bg_en", 32'(bg_enable), 32'd1);
    wait_idle(3000);
    check("queued_overrun_end", 32'(overrun), 32'd0);

    // Tick on the SP_FLUSH -> IDLE edge, then a tick in the IDLE cycle itself
    for (int v = 0; v < 2; v++) begin
      setup_random();
      pulse_tick();
      n = 0;
      while (sprite_enable !== 1'b1 && n < 3000) begin step(); n++; end
      while (sprite_enable === 1'b1 && n < 3000) begin step(); n++; end
      step();
      if (v == 0) frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      check("flush_tick_idle", 32'(frame_busy), 32'd0);
      if (v == 1) frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      check("flush_tick_busy", 32'(frame_busy), 32'd1);
      check("flush_tick_bg_en", 32'(bg_enable), 32'd1);
      wait_idle(3000);
      check("flush_tick_overrun", 32'(overrun), 32'd0);
    end

    // Third tick while one is already pending sets sticky overrun
    setup_random();
    pulse_tick();
    step();
    pulse_tick();
    check("ovr_after_2nd", 32'(overrun), 32'd0);
    pulse_tick();
    check("ovr_after_3rd", 32'(overrun), 32'd1);
    wait_idle(3000);
    step();
    check("ovr_queued_start", 32'(bg_enable), 32'd1);
    wait_idle(3000);
    for (int i = 0; i < 4; i++) step();
    check("ovr_no_third_frame", 32'(frame_busy), 32'd0);
    check("ovr_sticky", 32'(overrun), 32'd1);

    // Asynchronous reset in the middle of the background scan
    bx0 = 8'd0; by0 = 7'd0; bxmax = 8'd160; bymax = 7'd1;
    rearm();
    pulse_tick();
    n = 0;
    while (!(bg_enable === 1'b1 && bg_x == 8'd37) && n < 500) begin step(); n++; end
    check("reach_x37", 32'(bg_x), 32'd37);
    reset = 1'b1;
    #1;
    check("arst_bg_enable", 32'(bg_enable), 32'd0);
    check("arst_plot", 32'(vga_plot), 32'd0);
    check("arst_busy", 32'(frame_busy), 32'd0);
    check("arst_overrun", 32'(overrun), 32'd0);
    expq.delete();
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("post_rst_idle", 32'(frame_busy), 32'd0);
    end
    run_random_frame();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
